puf_eval_ctrl: RTL and testbench

Sequencer for the PUF excitation path. On `start` it builds a RESP_W-bit response one bit at a time. Each bit goes through the same three steps:

- drive `excite` high for a fixed window;
- let the cell settle;
- sample `puf_bit`.

The challenge advances after every bit. The assembled word is returned on a valid/ready handshake. The block sits between the PUF register interface and the PUF cell array, and replaces free-running enable/timer control.

---
 rtl/puf_eval_if.sv | 24 ++
 rtl/puf_eval_ctrl.sv | 142 ++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/puf_eval_if.sv
// Request/response bus between the PUF register interface (master) and the
// evaluation sequencer (slave).
interface puf_eval_if #(
  parameter int RESP_W = 32,
  parameter int CHAL_W = 8
) ();
  logic              start;
  logic              abort;
  logic [CHAL_W-1:0] chal_base;
  logic              busy;
  logic [RESP_W-1:0] resp;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output start, abort, chal_base, resp_ready,
    input  busy, resp, resp_valid
  );

  modport slave (
    input  start, abort, chal_base, resp_ready,
    output busy, resp, resp_valid
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// PUF excitation sequencer: excite / settle / sample per response bit.
// Optional macro PUF_MAJ_VOTE_EN: three evaluations per bit, majority-voted.
//
// state  | meaning
// IDLE   | waiting for start
// EXCITE | excite high, down-counting the excitation window
// SETTLE | excite low, down-counting the settle window
// SAMPLE | capture puf_bit into resp (or into vote storage)
// DONE   | resp_valid high until resp_ready
module puf_eval_ctrl #(
  parameter int RESP_W     = 32,
  parameter int CHAL_W     = 8,
  parameter int EXCITE_CYC = 15,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  puf_eval_if.slave         bus,
  input  logic              puf_bit,
  output logic              excite,
  output logic [CHAL_W-1:0] chal_out
);
  localparam int MAX_CYC = (EXCITE_CYC > SETTLE_CYC) ? EXCITE_CYC : SETTLE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  typedef enum logic [2:0] {IDLE, EXCITE, SETTLE, SAMPLE, DONE} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [RESP_W-1:0]  resp;
  logic               busy, resp_valid;
  logic               excite_d, busy_d, valid_d;
  logic               abort_act, last_bit, final_vote, bit_val;

  assign abort_act = bus.abort && (state != IDLE);
  assign last_bit  = (bit_idx == IDX_W'(RESP_W - 1));

`ifdef PUF_MAJ_VOTE_EN
  logic [1:0] vote_idx;
  logic [1:0] votes;

  assign final_vote = (vote_idx == 2'd2);
  assign bit_val    = (votes[0] & votes[1]) | (votes[0] & puf_bit) | (votes[1] & puf_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_idx <= '0;
      votes    <= '0;
    end else if (abort_act || state == IDLE) begin
      vote_idx <= '0;
    end else if (state == SAMPLE) begin
      if (final_vote) begin
        vote_idx <= '0;
      end else begin
        votes[vote_idx[0]] <= puf_bit;
        vote_idx           <= vote_idx + 2'd1;
      end
    end
  end
`else
  assign final_vote = 1'b1;
  assign bit_val    = puf_bit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_d = EXCITE;
      EXCITE:  if (cnt == '0) state_d = SETTLE;
      SETTLE:  if (cnt == '0) state_d = SAMPLE;
      SAMPLE:  state_d = (final_vote && last_bit) ? DONE : EXCITE;
      DONE:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    excite_d = (state_d == EXCITE);
    busy_d   = (state_d != IDLE);
    valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excite     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      excite     <= excite_d;
      busy       <= busy_d;
      resp_valid <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      chal_out <= '0;
      resp     <= '0;
    end else if (abort_act) begin
      cnt     <= '0;
      bit_idx <= '0;
      resp    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.abort) begin
          chal_out <= bus.chal_base;
          bit_idx  <= '0;
          cnt      <= CNT_W'(EXCITE_CYC - 1);
          resp     <= '0;
        end
        EXCITE: cnt <= (cnt == '0) ? CNT_W'(SETTLE_CYC - 1) : cnt - 1'b1;
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        SAMPLE: begin
          cnt <= CNT_W'(EXCITE_CYC - 1);
          if (final_vote) begin
            resp[bit_idx] <= bit_val;
            if (!last_bit) begin
              bit_idx  <= bit_idx + 1'b1;
              chal_out <= chal_out + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.resp       = resp;
  assign bus.resp_valid = resp_valid;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl; expected responses go through a
// scoreboard queue and are compared when resp_valid is seen.
module tb_puf_eval_ctrl;
  localparam int RESP_W = 4, CHAL_W = 8, EXCITE_CYC = 3, SETTLE_CYC = 2;
  localparam int P = EXCITE_CYC + SETTLE_CYC + 1;
`ifdef PUF_MAJ_VOTE_EN
  localparam int V = 3;
`else
  localparam int V = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              puf_bit = 1'b0;
  logic              excite;
  logic [CHAL_W-1:0] chal_out;

  puf_eval_if #(.RESP_W(RESP_W), .CHAL_W(CHAL_W)) bus ();

  puf_eval_ctrl #(
    .RESP_W(RESP_W), .CHAL_W(CHAL_W), .EXCITE_CYC(EXCITE_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .puf_bit(puf_bit), .excite(excite), .chal_out(chal_out)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                failures = 0;
  logic [RESP_W-1:0] sb[$];
  logic              samp [0:3*RESP_W-1];
  logic [RESP_W-1:0] fixed_exp;
  logic              seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one full response; samp[] holds the value presented at each SAMPLE.
  task automatic run_resp(input logic [7:0] base);
    logic [RESP_W-1:0] exp;
    logic [RESP_W-1:0] r;
    int last;
    exp = '0;
    for (int b = 0; b < RESP_W; b++) begin
      if (V == 3)
        exp[b] = (samp[3*b] & samp[3*b+1]) | (samp[3*b] & samp[3*b+2]) | (samp[3*b+1] & samp[3*b+2]);
      else
        exp[b] = samp[b];
    end
    sb.push_back(exp);
    last = V * RESP_W * P;
    bus.chal_base = base;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      if (c <= last) begin
        chk("excite", 32'(excite), 32'(((c - 1) % P) < EXCITE_CYC));
        chk("chal_out", 32'(chal_out), 32'(8'(base + (c - 1) / (V * P))));
        chk("busy", 32'(bus.busy), 32'd1);
      end
      chk("resp_valid", 32'(bus.resp_valid), 32'(c == last + 1));
      if (bus.resp_valid) begin
        chk("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          r = sb.pop_front();
          chk("resp", 32'(bus.resp), 32'(r));
        end
      end
      if (c % P == 0) puf_bit = samp[c/P - 1];
      else if (c / P < V * RESP_W) puf_bit = ~samp[c/P];
      else puf_bit = 1'b0;
      tick;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.chal_base = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    tick;
    tick;
    chk("rst_excite", 32'(excite), 32'd0);
    chk("rst_chal", 32'(chal_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp", 32'(bus.resp), 32'd0);
    chk("rst_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < 3 * RESP_W; i++) samp[i] = 1'b0;
`ifdef PUF_MAJ_VOTE_EN
    samp[0] = 1'b1; samp[1] = 1'b0; samp[2] = 1'b1;
    samp[3] = 1'b0; samp[4] = 1'b0; samp[5] = 1'b1;
    fixed_exp = 4'b0001;
`else
    samp[0] = 1'b1; samp[1] = 1'b0; samp[2] = 1'b1; samp[3] = 1'b1;
    fixed_exp = 4'b1101;
`endif
    run_resp(8'hFE);

    // Backpressure, then a start in the handshake cycle that must be dropped.
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_resp", 32'(bus.resp), 32'(fixed_exp));
      chk("bp_busy", 32'(bus.busy), 32'd1);
      tick;
    end
    bus.resp_ready = 1'b1;
    bus.start = 1'b1;
    bus.chal_base = 8'h55;
    tick;
    bus.resp_ready = 1'b0;
    bus.start = 1'b0;
    chk("hs_valid", 32'(bus.resp_valid), 32'd0);
    chk("hs_busy", 32'(bus.busy), 32'd0);
    chk("hs_resp_kept", 32'(bus.resp), 32'(fixed_exp));
    tick;
    chk("hs_start_ignored", 32'(bus.busy), 32'd0);
    chk("hs_excite", 32'(excite), 32'd0);

    // Abort during bit 1 settle.
    bus.chal_base = 8'h20;
    bus.start = 1'b1;
    puf_bit = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick;
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("ab_excite", 32'(excite), 32'd0);
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_resp", 32'(bus.resp), 32'd0);
    chk("ab_valid", 32'(bus.resp_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | bus.resp_valid;
      tick;
    end
    chk("ab_no_valid", 32'(seen), 32'd0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("ab_start_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("ab_start_excite", 32'(excite), 32'd0);

    // Asynchronous reset mid-excite.
    bus.chal_base = 8'h33;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    chk("ar_excite_pre", 32'(excite), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_excite", 32'(excite), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_valid", 32'(bus.resp_valid), 32'd0);
    chk("ar_chal", 32'(chal_out), 32'd0);
    tick;
    rst = 1'b0;
    tick;
    for (int i = 0; i < 3 * RESP_W; i++) samp[i] = 1'($urandom_range(0, 1));
    run_resp(8'h10);
    bus.resp_ready = 1'b1;
    tick;
    bus.resp_ready = 1'b0;
    chk("ar_final_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
